div_seq: RTL and testbench
==========================

# div_seq

Sequential restoring divider for the DDCO division datapath: a controller FSM sequencing a shift/trial-subtract/restore datapath one quotient bit per clock. Each iteration uses the team's 2:1 mux function to choose between the trial difference and the restored partial remainder. The block accepts unsigned operands on a start pulse and returns quotient and remainder with a done pulse. It is the top-level compute block the project's board wrapper and testbench drive.

## Interface
- WIDTH, 8, operand/result width in bits (≥2)
- clk  input  1  rising-edge clock
- rst_n  input  1  reset, asynchronous, active-low
- start  input  1  request; sampled only in IDLE
- dividend  input  WIDTH  unsigned dividend, captured on accepted start
- divisor  input  WIDTH  unsigned divisor, captured on accepted start
- quotient  output  WIDTH  registered result, held until next completion
- remainder  output  WIDTH  registered result, held until next completion
- busy  output  1  high from the edge accepting start until the edge entering DONE
- done  output  1  one-cycle completion pulse
- div_by_zero  output  1  qualifies the current result; see Configuration

## Operation
- Reset values: quotient=0, remainder=0, busy=0, done=0, div_by_zero=0, state=IDLE, iteration count=0.
- States: IDLE, RUN, DONE.
- IDLE: on start=1, capture dividend into Q (WIDTH), divisor into D (WIDTH), clear R (WIDTH+1), count=0; go to RUN, busy=1.
- RUN, per edge: shift {R,Q} left 1; trial = R_shifted − {1'b0,D} in WIDTH+1 bits; sel = ~trial[WIDTH]; R ← mux(d0=R_shifted, d1=trial, s=sel); Q[0] ← sel; count+1.
- After the WIDTH-th iteration: load quotient←Q, remainder←R[WIDTH-1:0], go to DONE, busy=0, done=1.
- DONE: done=1 for exactly one cycle; next edge → IDLE unconditionally.
- start in RUN or DONE: ignored, not queued; operands on those cycles have no effect.
- Captured operands are immune to input changes after acceptance.
- Divisor 0 through the normal path yields quotient all ones, remainder = dividend.
- rst_n low at any time, including mid-RUN: all state and outputs return to reset values immediately; partial result discarded.

## Timing
- Edge E0 accepts start; busy high after E0.
- Iterations on E1..EWIDTH; at EWIDTH, quotient/remainder update, busy falls, done rises.
- E(WIDTH+1): done falls, state IDLE; earliest next accept is E(WIDTH+2) (start must be high in the cycle after done).
- Latency start-accept to done: WIDTH+... exactly WIDTH edges; throughput one division per WIDTH+2 cycles.
- No combinational path from inputs to outputs.

## Configuration
- Macro DIV_ZERO_CHECK_EN.
- Defined: in IDLE, accepted start with divisor==0 skips RUN; at E1 quotient←all ones, remainder←dividend, div_by_zero←1, done=1 (busy high for one cycle). div_by_zero clears on the next completion with nonzero divisor and on reset.
- Not defined: no detection; divisor 0 runs WIDTH iterations, same result values at EWIDTH; div_by_zero tied 0.

## Test plan
- WIDTH=8, dividend=100, divisor=7, start at E0 -> done at E8 only, quotient=14, remainder=2, busy high E0–E8.
- dividend=255/divisor=1 then 5/9 back-to-back (start in cycle after done) -> 255 r0, then 0 r5; second done exactly 10 edges after first.
- dividend=200, divisor=0 -> with DIV_ZERO_CHECK_EN: done at E1, quotient=0xFF, remainder=200, div_by_zero=1; without: done at E8, same values, div_by_zero=0.
- start with 100/7, then start=1 with 50/5 at E3 and change operand inputs during RUN -> second request ignored; result 14 r2 at E8.
- start 100/7, assert rst_n=0 asynchronously mid-E4 -> all outputs 0 immediately, no done; after release, 60/6 -> quotient=10, remainder=0.
- Exhaustive sweep WIDTH=4, all dividend × divisor≠0 -> quotient and remainder match reference integer division on every done.

Source files
------------

// File: rtl/div_seq.sv
// Sequential restoring divider: one quotient bit per clock, start/done handshake.
// Optional macro DIV_ZERO_CHECK_EN short-circuits a zero divisor to a one-cycle result.
module div_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero
);

  localparam int CNT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] q_reg, d_reg;
  // The restored partial remainder is always below the divisor, so its top bit
  // is permanently zero and only WIDTH bits are held.
  logic [WIDTH-1:0] r_reg;
  logic [CNT_W-1:0] count;

  logic [WIDTH:0]   r_shift, trial;
  logic [WIDTH-1:0] r_next, q_next;
  logic             sel;
  logic             accept, finish, last_iter, zero_skip;
  logic [WIDTH-1:0] fin_q, fin_r;

  function automatic logic [WIDTH-1:0] mux2(input logic [WIDTH-1:0] d0,
                                            input logic [WIDTH-1:0] d1,
                                            input logic             s);
    return s ? d1 : d0;
  endfunction

  // One restoring step: shift {R,Q}, trial-subtract, keep the difference if non-negative.
  assign r_shift   = {r_reg, q_reg[WIDTH-1]};
  assign trial     = r_shift - {1'b0, d_reg};
  assign sel       = ~trial[WIDTH];
  assign r_next    = mux2(r_shift[WIDTH-1:0], trial[WIDTH-1:0], sel);
  assign q_next    = {q_reg[WIDTH-2:0], sel};
  assign last_iter = (count == CNT_W'(WIDTH - 1));

`ifdef DIV_ZERO_CHECK_EN
  logic dz_flag;
  assign zero_skip = dz_flag;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dz_flag     <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      if (accept) dz_flag <= (divisor == '0);
      if (finish) div_by_zero <= dz_flag;
    end
  end
`else
  assign zero_skip   = 1'b0;
  assign div_by_zero = 1'b0;
`endif

  // Zero-divisor short cut returns all ones and the untouched dividend still in Q.
  assign fin_q = zero_skip ? '1    : q_next;
  assign fin_r = zero_skip ? q_reg : r_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // NOTE: every signal written here gets a default first so no latch is inferred
  // on paths that do not assign it.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    finish     = 1'b0;
    case (state)
      IDLE: if (start) begin
        accept     = 1'b1;
        state_next = RUN;
      end
      RUN: if (last_iter || zero_skip) begin
        finish     = 1'b1;
        state_next = DONE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register in
  // this block samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_reg     <= '0;
      d_reg     <= '0;
      r_reg     <= '0;
      count     <= '0;
      quotient  <= '0;
      remainder <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        q_reg <= dividend;
        d_reg <= divisor;
        r_reg <= '0;
        count <= '0;
        busy  <= 1'b1;
      end else if (state == RUN) begin
        q_reg <= q_next;
        r_reg <= r_next;
        count <= count + CNT_W'(1);
        if (finish) begin
          quotient  <= fin_q;
          remainder <= fin_r;
          busy      <= 1'b0;
          done      <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_div_seq.sv
// Self-checking bench for div_seq: directed scenarios, random 8-bit divisions and
// an exhaustive 4-bit sweep, all checked against plain integer division.
module tb_div_seq;

`ifdef DIV_ZERO_CHECK_EN
  localparam bit ZERO_CHECK = 1'b1;
`else
  localparam bit ZERO_CHECK = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start8;
  logic [7:0] a8, b8, q8, r8;
  logic       busy8, done8, dz8;
  logic       start4;
  logic [3:0] a4, b4, q4, r4;
  logic       busy4, done4, dz4;

  int errors = 0;
  int checks = 0;
  int edge_cnt = 0;

  div_seq #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .dividend(a8), .divisor(b8),
    .quotient(q8), .remainder(r8), .busy(busy8), .done(done8), .div_by_zero(dz8)
  );

  div_seq #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .dividend(a4), .divisor(b4),
    .quotient(q4), .remainder(r4), .busy(busy4), .done(done4), .div_by_zero(dz4)
  );

  always #5 clk = ~clk;
  always @(posedge clk) edge_cnt++;

  function automatic int ref_quot(int a, int b, int w);
    return (b == 0) ? (1 << w) - 1 : a / b;
  endfunction

  function automatic int ref_rem(int a, int b);
    return (b == 0) ? a : a % b;
  endfunction

  function automatic int ref_lat(int b, int w);
    return (b == 0 && ZERO_CHECK) ? 1 : w;
  endfunction

  function automatic bit ref_dz(int b);
    return (b == 0) && ZERO_CHECK;
  endfunction

  // Issues one request from a negedge; returns at the negedge after the done edge.
  // lat = edges from the accepting edge to done (-1 on timeout).
  task automatic run8(input logic [7:0] a, input logic [7:0] b, input bit noisy,
                      output int lat, output bit busy_ok);
    int e0;
    busy_ok = 1'b1;
    lat     = -1;
    start8  = 1'b1;
    a8      = a;
    b8      = b;
    @(posedge clk);
    @(negedge clk);
    e0 = edge_cnt;
    if (!noisy) start8 = 1'b0;
    a8 = 8'($urandom);
    b8 = 8'($urandom);
    if (busy8 !== 1'b1) busy_ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (noisy) begin
        a8 = 8'($urandom);
        b8 = 8'($urandom);
      end
      @(posedge clk);
      @(negedge clk);
      if (done8 === 1'b1) begin
        lat = edge_cnt - e0;
        if (busy8 !== 1'b0) busy_ok = 1'b0;
        break;
      end
      if (busy8 !== 1'b1) busy_ok = 1'b0;
    end
    start8 = 1'b0;
  endtask

  task automatic run4(input logic [3:0] a, input logic [3:0] b, output int lat);
    int e0;
    lat    = -1;
    start4 = 1'b1;
    a4     = a;
    b4     = b;
    @(posedge clk);
    @(negedge clk);
    e0     = edge_cnt;
    start4 = 1'b0;
    a4     = 4'($urandom);
    b4     = 4'($urandom);
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (done4 === 1'b1) begin
        lat = edge_cnt - e0;
        break;
      end
    end
  endtask

  task automatic test_reset;
    #3;
    checks++;
    if ({q8, r8, busy8, done8, dz8} !== '0) begin
      errors++;
      $display("FAIL reset8: got q=%0d r=%0d busy=%b done=%b dz=%b expected all 0",
               q8, r8, busy8, done8, dz8);
    end
    checks++;
    if ({q4, r4, busy4, done4, dz4} !== '0) begin
      errors++;
      $display("FAIL reset4: got q=%0d r=%0d busy=%b done=%b dz=%b expected all 0",
               q4, r4, busy4, done4, dz4);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic;
    int lat;
    bit bok;
    run8(8'd100, 8'd7, 1'b0, lat, bok);
    checks++;
    if (lat !== 8 || bok !== 1'b1) begin
      errors++;
      $display("FAIL basic_timing: got lat=%0d busy_ok=%0d expected lat=8 busy_ok=1", lat, bok);
    end
    checks++;
    if (q8 !== 8'd14 || r8 !== 8'd2 || dz8 !== 1'b0) begin
      errors++;
      $display("FAIL basic_result: got q=%0d r=%0d dz=%b expected q=14 r=2 dz=0", q8, r8, dz8);
    end
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (done8 !== 1'b0 || busy8 !== 1'b0 || q8 !== 8'd14) begin
      errors++;
      $display("FAIL basic_done_pulse: got done=%b busy=%b q=%0d expected done=0 busy=0 q=14",
               done8, busy8, q8);
    end
  endtask

  task automatic test_back_to_back;
    int lat1, lat2, e1;
    bit bok;
    run8(8'd255, 8'd1, 1'b0, lat1, bok);
    e1 = edge_cnt;
    checks++;
    if (q8 !== 8'd255 || r8 !== 8'd0 || lat1 !== 8) begin
      errors++;
      $display("FAIL b2b_first: got q=%0d r=%0d lat=%0d expected q=255 r=0 lat=8", q8, r8, lat1);
    end
    @(posedge clk);
    @(negedge clk);
    run8(8'd5, 8'd9, 1'b0, lat2, bok);
    checks++;
    if (q8 !== 8'd0 || r8 !== 8'd5 || edge_cnt - e1 !== 10) begin
      errors++;
      $display("FAIL b2b_second: got q=%0d r=%0d spacing=%0d expected q=0 r=5 spacing=10",
               q8, r8, edge_cnt - e1);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_zero_divisor;
    int lat;
    bit bok;
    run8(8'd200, 8'd0, 1'b0, lat, bok);
    checks++;
    if (lat !== ref_lat(0, 8) || bok !== 1'b1) begin
      errors++;
      $display("FAIL zero_timing: got lat=%0d busy_ok=%0d expected lat=%0d busy_ok=1",
               lat, bok, ref_lat(0, 8));
    end
    checks++;
    if (q8 !== 8'hFF || r8 !== 8'd200 || dz8 !== ref_dz(0)) begin
      errors++;
      $display("FAIL zero_result: got q=%0d r=%0d dz=%b expected q=255 r=200 dz=%b",
               q8, r8, dz8, ref_dz(0));
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_ignore_start;
    int lat;
    bit bok, stray;
    run8(8'd100, 8'd7, 1'b1, lat, bok);
    checks++;
    if (q8 !== 8'd14 || r8 !== 8'd2 || lat !== 8) begin
      errors++;
      $display("FAIL ignore_result: got q=%0d r=%0d lat=%0d expected q=14 r=2 lat=8", q8, r8, lat);
    end
    stray = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (busy8 !== 1'b0 || done8 !== 1'b0) stray = 1'b1;
    end
    checks++;
    if (stray !== 1'b0) begin
      errors++;
      $display("FAIL ignore_not_queued: got stray activity=%b expected 0", stray);
    end
  endtask

  task automatic test_reset_mid_run;
    int lat;
    bit bok, seen_done;
    start8 = 1'b1;
    a8     = 8'd100;
    b8     = 8'd7;
    @(posedge clk);
    @(negedge clk);
    start8 = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({q8, r8, busy8, done8, dz8} !== '0) begin
      errors++;
      $display("FAIL midrun_reset: got q=%0d r=%0d busy=%b done=%b dz=%b expected all 0",
               q8, r8, busy8, done8, dz8);
    end
    seen_done = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done8 !== 1'b0 || busy8 !== 1'b0) seen_done = 1'b1;
      if (i == 2) rst_n = 1'b1;
    end
    checks++;
    if (seen_done !== 1'b0) begin
      errors++;
      $display("FAIL midrun_discard: got done/busy activity=%b expected 0", seen_done);
    end
    run8(8'd60, 8'd6, 1'b0, lat, bok);
    checks++;
    if (q8 !== 8'd10 || r8 !== 8'd0 || lat !== 8 || bok !== 1'b1) begin
      errors++;
      $display("FAIL midrun_after: got q=%0d r=%0d lat=%0d busy_ok=%0d expected q=10 r=0 lat=8 busy_ok=1",
               q8, r8, lat, bok);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_random;
    int a, b, lat;
    bit bok;
    for (int n = 0; n < 24; n++) begin
      a = int'($urandom_range(0, 255));
      b = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 255));
      run8(8'(a), 8'(b), n[0], lat, bok);
      checks++;
      if (q8 !== 8'(ref_quot(a, b, 8)) || r8 !== 8'(ref_rem(a, b)) || dz8 !== ref_dz(b)
          || lat !== ref_lat(b, 8) || bok !== 1'b1) begin
        errors++;
        $display("FAIL random %0d/%0d: got q=%0d r=%0d dz=%b lat=%0d busy_ok=%0d expected q=%0d r=%0d dz=%b lat=%0d busy_ok=1",
                 a, b, q8, r8, dz8, lat, bok, ref_quot(a, b, 8), ref_rem(a, b), ref_dz(b), ref_lat(b, 8));
      end
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic test_sweep4;
    int lat;
    for (int a = 0; a < 16; a++) begin
      for (int b = 1; b < 16; b++) begin
        run4(4'(a), 4'(b), lat);
        checks++;
        if (q4 !== 4'(a / b) || r4 !== 4'(a % b) || lat !== 4) begin
          errors++;
          $display("FAIL sweep4 %0d/%0d: got q=%0d r=%0d lat=%0d expected q=%0d r=%0d lat=4",
                   a, b, q4, r4, lat, a / b, a % b);
        end
        @(posedge clk);
        @(negedge clk);
      end
    end
  endtask

  initial begin
    rst_n  = 1'b0;
    start8 = 1'b0;
    a8     = '0;
    b8     = '0;
    start4 = 1'b0;
    a4     = '0;
    b4     = '0;
    test_reset;
    test_basic;
    test_back_to_back;
    test_zero_divisor;
    test_ignore_start;
    test_reset_mid_run;
    test_random;
    test_sweep4;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
